// File: rtl/uart_pkg.sv
// Shared UART constants and state encoding.
// Both the transmit framer and the receive deframer use this package.
package uart_pkg;

    localparam int DATA_W     = 8;
    localparam int FRAME_W    = 11;

    localparam int START_IDX  = 0;
    localparam int DATA_LSB   = 1;
    localparam int DATA_MSB   = 8;
    localparam int PARITY_IDX = 9;
    localparam int STOP_IDX   = 10;

    localparam logic IDLE_LVL = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

endpackage

// File: rtl/uart_tx_framer_if.sv
// Byte-wide TX handshake between the core and the UART framer.
// The core side is master; the framer side is slave.
interface uart_tx_framer_if;
    import uart_pkg::*;

    logic              tx_start;
    logic [DATA_W-1:0] tx_data;
    logic              tx_serial;
    logic              tx_busy;
    logic              tx_done;

    modport master (
        output tx_start,
        output tx_data,
        input  tx_serial,
        input  tx_busy,
        input  tx_done
    );

    modport slave (
        input  tx_start,
        input  tx_data,
        output tx_serial,
        output tx_busy,
        output tx_done
    );

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-time generator: bit_tick pulses on the last clock of each bit.
// The counter is held at zero whenever en is low.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic bit_tick
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last   = (r_cnt == LAST);
    assign bit_tick = en && w_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (!en || w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: 11-bit frame {stop, parity, data, start}, LSB first.
// Define UART_TX_PARITY_EN for even parity in bit 9; otherwise bit 9 is mark.
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input logic             clk,
    input logic             reset,
    uart_tx_framer_if.slave bus
);

    state_t             r_state;
    state_t             w_next;
    logic [3:0]         r_bit_cnt;
    logic [FRAME_W-1:0] r_sr;
    logic               r_busy;
    logic               r_done;

    logic               w_en;
    logic               w_tick;
    logic               w_load;
    logic               w_busy_nxt;
    logic               w_done_nxt;
    logic               w_par;
    logic [FRAME_W-1:0] w_frame;

    assign w_en = (r_state != IDLE);

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .reset   (reset),
        .en      (w_en),
        .bit_tick(w_tick)
    );

`ifdef UART_TX_PARITY_EN
    assign w_par = ^bus.tx_data;
`else
    assign w_par = 1'b1;
`endif

    always_comb begin
        w_frame                    = '1;
        w_frame[START_IDX]         = ~IDLE_LVL;
        w_frame[DATA_MSB:DATA_LSB] = bus.tx_data;
        w_frame[PARITY_IDX]        = w_par;
        w_frame[STOP_IDX]          = IDLE_LVL;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (bus.tx_start) w_next = START;
            end
            START: begin
                if (w_tick && r_bit_cnt == 4'(START_IDX)) w_next = DATA;
            end
            DATA: begin
                if (w_tick && r_bit_cnt == 4'(DATA_MSB)) w_next = PARITY;
            end
            PARITY: begin
                if (w_tick && r_bit_cnt == 4'(PARITY_IDX)) w_next = STOP;
            end
            STOP: begin
                if (w_tick && r_bit_cnt == 4'(STOP_IDX)) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_load     = (r_state == IDLE) && bus.tx_start;
        w_busy_nxt = (w_next != IDLE);
        w_done_nxt = (r_state == STOP) && (w_next == IDLE);
    end

    // Shift register idles at all ones so sr[0] is the line in every state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sr      <= '1;
            r_bit_cnt <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
            if (w_load) begin
                r_sr      <= w_frame;
                r_bit_cnt <= '0;
            end else if (w_tick) begin
                r_sr <= {IDLE_LVL, r_sr[FRAME_W-1:1]};
                if (r_bit_cnt == 4'(STOP_IDX)) begin
                    r_bit_cnt <= '0;
                end else begin
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                end
            end
        end
    end

    assign bus.tx_serial = r_sr[0];
    assign bus.tx_busy   = r_busy;
    assign bus.tx_done   = r_done;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer at CLKS_PER_BIT = 4.
// Expected parity follows UART_TX_PARITY_EN.
module tb_uart_tx_framer;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic clk;
    logic reset;
    int   ntests;
    int   nfail;

    uart_tx_framer_if bus ();

    uart_tx_framer #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [10:0] mk_frame(input logic [7:0] d,
                                             input logic hand_par);
        logic p;
        p = PAR_EN ? hand_par : 1'b1;
        return {1'b1, p, d, 1'b0};
    endfunction

    task automatic send(input logic [7:0] d);
        @(negedge clk);
        bus.tx_start = 1'b1;
        bus.tx_data  = d;
        @(negedge clk);
        bus.tx_start = 1'b0;
    endtask

    // Called in the first busy cycle; returns at the cycle after the done cycle.
    task automatic capture(input int inj_at, input logic [7:0] inj_d,
                           output logic [10:0] fr, output int cycles,
                           output logic done0, output logic ser0,
                           output logic done1);
        int k;
        k  = 0;
        fr = '0;
        while (bus.tx_busy && k < 200) begin
            if (k % CPB == CPB / 2) fr[k / CPB] = bus.tx_serial;
            if (k == inj_at) begin
                bus.tx_start = 1'b1;
                bus.tx_data  = inj_d;
            end else if (k == inj_at + 1) begin
                bus.tx_start = 1'b0;
            end
            k++;
            @(negedge clk);
        end
        cycles = k;
        done0  = bus.tx_done;
        ser0   = bus.tx_serial;
        @(negedge clk);
        done1  = bus.tx_done;
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        bus.tx_start = 1'b0;
        bus.tx_data  = 8'h00;
        repeat (3) @(negedge clk);
        ntests++;
        if (bus.tx_serial !== 1'b1) begin
            nfail++;
            $display("FAIL reset_serial got %b want 1", bus.tx_serial);
        end
        ntests++;
        if (bus.tx_busy !== 1'b0) begin
            nfail++;
            $display("FAIL reset_busy got %b want 0", bus.tx_busy);
        end
        ntests++;
        if (bus.tx_done !== 1'b0) begin
            nfail++;
            $display("FAIL reset_done got %b want 0", bus.tx_done);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_a5();
        logic [10:0] fr;
        int          cyc;
        logic        d0, s0, d1;
        send(8'hA5);
        ntests++;
        if (bus.tx_serial !== 1'b0 || bus.tx_busy !== 1'b1) begin
            nfail++;
            $display("FAIL a5_latency ser=%b busy=%b want 0/1",
                     bus.tx_serial, bus.tx_busy);
        end
        capture(-10, 8'h00, fr, cyc, d0, s0, d1);
        ntests++;
        if (fr !== mk_frame(8'hA5, 1'b0)) begin
            nfail++;
            $display("FAIL a5_frame got %b want %b", fr,
                     mk_frame(8'hA5, 1'b0));
        end
        ntests++;
        if (cyc != 44) begin
            nfail++;
            $display("FAIL a5_busy_cycles got %0d want 44", cyc);
        end
        ntests++;
        if (d0 !== 1'b1 || s0 !== 1'b1) begin
            nfail++;
            $display("FAIL a5_done_cycle done=%b ser=%b want 1/1", d0, s0);
        end
        ntests++;
        if (d1 !== 1'b0) begin
            nfail++;
            $display("FAIL a5_done_width got %b want 0", d1);
        end
    endtask

    task automatic test_parity();
        logic [10:0] fr;
        int          cyc;
        logic        d0, s0, d1;
        send(8'h01);
        capture(-10, 8'h00, fr, cyc, d0, s0, d1);
        ntests++;
        if (fr !== mk_frame(8'h01, 1'b1)) begin
            nfail++;
            $display("FAIL par_01 got %b want %b", fr,
                     mk_frame(8'h01, 1'b1));
        end
        send(8'h00);
        capture(-10, 8'h00, fr, cyc, d0, s0, d1);
        ntests++;
        if (fr !== mk_frame(8'h00, 1'b0)) begin
            nfail++;
            $display("FAIL par_00 got %b want %b", fr,
                     mk_frame(8'h00, 1'b0));
        end
    endtask

    task automatic test_ignore_busy();
        logic [10:0] fr;
        int          cyc;
        logic        d0, s0, d1;
        int          extra;
        send(8'hFF);
        capture(10, 8'h3C, fr, cyc, d0, s0, d1);
        ntests++;
        if (fr !== mk_frame(8'hFF, 1'b0) || cyc != 44) begin
            nfail++;
            $display("FAIL ignore_frame got %b/%0d want %b/44", fr, cyc,
                     mk_frame(8'hFF, 1'b0));
        end
        extra = 0;
        for (int i = 0; i < 30; i++) begin
            if (bus.tx_busy !== 1'b0 || bus.tx_serial !== 1'b1) extra++;
            @(negedge clk);
        end
        ntests++;
        if (extra != 0) begin
            nfail++;
            $display("FAIL ignore_no_second got %0d active cycles want 0",
                     extra);
        end
    endtask

    task automatic test_reset_mid();
        logic [10:0] fr;
        int          cyc;
        logic        d0, s0, d1;
        int          dones;
        send(8'h5A);
        repeat (17) @(negedge clk);
        ntests++;
        if (bus.tx_serial !== 1'b1 || bus.tx_busy !== 1'b1) begin
            nfail++;
            $display("FAIL mid_bit3 ser=%b busy=%b want 1/1",
                     bus.tx_serial, bus.tx_busy);
        end
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        #0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        for (int i = 0; i < 50; i++) begin
            if (bus.tx_done === 1'b1) dones++;
            @(negedge clk);
        end
        ntests++;
        if (dones != 0) begin
            nfail++;
            $display("FAIL mid_no_done got %0d pulses want 0", dones);
        end
        send(8'hC3);
        capture(-10, 8'h00, fr, cyc, d0, s0, d1);
        ntests++;
        if (fr !== mk_frame(8'hC3, 1'b0) || cyc != 44 || d0 !== 1'b1) begin
            nfail++;
            $display("FAIL mid_recover got %b/%0d/%b want %b/44/1", fr, cyc,
                     d0, mk_frame(8'hC3, 1'b0));
        end
    endtask

    task automatic test_reset_async();
        send(8'h5A);
        repeat (17) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        ntests++;
        if (bus.tx_serial !== 1'b1 || bus.tx_busy !== 1'b0) begin
            nfail++;
            $display("FAIL async_reset ser=%b busy=%b want 1/0",
                     bus.tx_serial, bus.tx_busy);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [89:0] ser;
        logic [89:0] bsy;
        logic [89:0] dn;
        logic [10:0] f1;
        logic [10:0] f2;
        int          dcount;
        @(negedge clk);
        bus.tx_start = 1'b1;
        bus.tx_data  = 8'h55;
        @(negedge clk);
        for (int k = 0; k < 90; k++) begin
            ser[k] = bus.tx_serial;
            bsy[k] = bus.tx_busy;
            dn[k]  = bus.tx_done;
            if (k == 0) bus.tx_data = 8'hAA;
            if (k == 89) bus.tx_start = 1'b0;
            @(negedge clk);
        end
        for (int b = 0; b < 11; b++) begin
            f1[b] = ser[b * CPB + CPB / 2];
            f2[b] = ser[45 + b * CPB + CPB / 2];
        end
        ntests++;
        if (f1 !== mk_frame(8'h55, 1'b0)) begin
            nfail++;
            $display("FAIL b2b_frame1 got %b want %b", f1,
                     mk_frame(8'h55, 1'b0));
        end
        ntests++;
        if (f2 !== mk_frame(8'hAA, 1'b0)) begin
            nfail++;
            $display("FAIL b2b_frame2 got %b want %b", f2,
                     mk_frame(8'hAA, 1'b0));
        end
        ntests++;
        if (ser[44] !== 1'b1 || bsy[44] !== 1'b0 || bsy[43] !== 1'b1) begin
            nfail++;
            $display("FAIL b2b_gap ser=%b busy=%b prev_busy=%b want 1/0/1",
                     ser[44], bsy[44], bsy[43]);
        end
        ntests++;
        if (ser[45] !== 1'b0 || bsy[45] !== 1'b1) begin
            nfail++;
            $display("FAIL b2b_restart ser=%b busy=%b want 0/1",
                     ser[45], bsy[45]);
        end
        dcount = 0;
        for (int k = 0; k < 90; k++) if (dn[k] === 1'b1) dcount++;
        ntests++;
        if (dcount != 2 || dn[44] !== 1'b1 || dn[89] !== 1'b1) begin
            nfail++;
            $display("FAIL b2b_done count=%0d d44=%b d89=%b want 2/1/1",
                     dcount, dn[44], dn[89]);
        end
        @(negedge clk);
        ntests++;
        if (bus.tx_busy !== 1'b0) begin
            nfail++;
            $display("FAIL b2b_stop got busy=%b want 0", bus.tx_busy);
        end
    endtask

    initial begin
        ntests = 0;
        nfail  = 0;
        test_reset();
        test_a5();
        test_parity();
        test_ignore_busy();
        test_reset_async();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
